// File: rtl/neuron_activation_fifo_if.sv
// Valid/ready handshake bundle for the activation FIFO: upstream (in_*) and downstream (out_*) streams.
// The master modport is the surrounding datapath; the slave modport is the FIFO itself.
interface neuron_activation_fifo_if #(
  parameter int exp_width  = 8,
  parameter int mant_width = 24
);
  logic                            in_valid;
  logic                            in_ready;
  logic [exp_width+mant_width-1:0] in_data;
  logic [4:0]                      in_exceptions;
  logic                            out_valid;
  logic                            out_ready;
  logic [exp_width+mant_width-1:0] out_data;
  logic [4:0]                      out_exceptions;

  modport master (
    output in_valid, in_data, in_exceptions, out_ready,
    input  in_ready, out_valid, out_data, out_exceptions
  );

  modport slave (
    input  in_valid, in_data, in_exceptions, out_ready,
    output in_ready, out_valid, out_data, out_exceptions
  );
endinterface

// File: rtl/neuron_activation_fifo.sv
// ReLU activation + circular FIFO behind the FP dot-product block, with sticky exception OR.
// Build macro NEURON_RELU_EN enables ReLU at push; undefined gives a bit-exact linear pass-through.
module neuron_activation_fifo #(
  parameter int exp_width  = 8,
  parameter int mant_width = 24,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  neuron_activation_fifo_if.slave  bus,
  input  logic                     clear_sticky,
  output logic [4:0]               sticky_exceptions,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int DATA_W = exp_width + mant_width;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [4:0]        r_exc [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [4:0]        r_sticky;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_act;

`ifdef NEURON_RELU_EN
  // NaN payloads pass untouched regardless of sign; every other negative word collapses to +0.0
  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] d);
    logic is_nan;
    is_nan = (&d[DATA_W-2:mant_width-1]) && (|d[mant_width-2:0]);
    if (d[DATA_W-1] && !is_nan) relu = '0;
    else                        relu = d;
  endfunction

  assign w_act = relu(bus.in_data);
`else
  assign w_act = bus.in_data;
`endif

  assign w_in_ready  = (r_count != FULL);
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  // Stage p0: storage write; data is not reset, only control state is
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_act;
      r_exc[r_wr_ptr] <= bus.in_exceptions;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_sticky <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // A push in the same cycle as a clear still lands in the sticky vector
      r_sticky <= (clear_sticky ? 5'b0 : r_sticky) | (w_push ? bus.in_exceptions : 5'b0);
    end
  end

  // Stage p1: head entry read straight from storage
  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_data       = r_mem[r_rd_ptr];
  assign bus.out_exceptions = r_exc[r_rd_ptr];
  assign sticky_exceptions  = r_sticky;
  assign count              = r_count;
endmodule

// File: tb/tb_neuron_activation_fifo.sv
// Randomized + directed bench for neuron_activation_fifo against a queue-based reference model.
module tb_neuron_activation_fifo;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  e;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear_sticky = 1'b0;
  logic [4:0] sticky_exceptions;
  logic [2:0] count;

  neuron_activation_fifo_if #(.exp_width(8), .mant_width(24)) bus ();

  neuron_activation_fifo #(.exp_width(8), .mant_width(24), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .clear_sticky      (clear_sticky),
    .sticky_exceptions (sticky_exceptions),
    .count             (count)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  ent_t q[$];
  logic [4:0] m_sticky = 5'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  // Activation rule from the datasheet: negative non-NaN words become +0.0
  function automatic logic [31:0] model_act(input logic [31:0] w);
    logic [7:0]  e;
    logic [22:0] m;
    e = w[30:23];
    m = w[22:0];
`ifdef NEURON_RELU_EN
    if (w[31] == 1'b1 && !(e == 8'hFF && m != 23'd0)) return 32'h0;
`endif
    return w;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0: return 32'h80000000;
      1: return 32'hFF800000;
      2: return 32'hFFC00001;
      3: return 32'h7FC00000;
      4: return 32'h80000001;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, "_count"},  32'(count), 32'(q.size()));
    check_eq({tag, "_ready"},  32'(bus.in_ready), 32'(q.size() < DEPTH));
    check_eq({tag, "_valid"},  32'(bus.out_valid), 32'(q.size() != 0));
    check_eq({tag, "_sticky"}, 32'(sticky_exceptions), 32'(m_sticky));
    if (q.size() != 0) begin
      check_eq({tag, "_data"}, bus.out_data, q[0].d);
      check_eq({tag, "_exc"},  32'(bus.out_exceptions), 32'(q[0].e));
    end
  endtask

  task automatic cycle(input string tag);
    bit push, pop;
    logic [31:0] d;
    logic [4:0]  e;
    logic        clr;
    push = bus.in_valid && (q.size() < DEPTH);
    pop  = bus.out_ready && (q.size() != 0);
    d    = bus.in_data;
    e    = bus.in_exceptions;
    clr  = clear_sticky;
    @(posedge clk);
    #1;
    if (pop)  q.delete(0);
    if (push) q.push_back({model_act(d), e});
    m_sticky = (clr ? 5'b0 : m_sticky) | (push ? e : 5'b0);
    check_state(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] e, input logic r);
    bus.in_valid      = v;
    bus.in_data       = d;
    bus.in_exceptions = e;
    bus.out_ready     = r;
  endtask

  logic [31:0] relu_in  [5] = '{32'hC0400000, 32'h40400000, 32'h80000000, 32'hFFC00000, 32'hFF800000};
  logic [31:0] relu_out [5] = '{32'h00000000, 32'h40400000, 32'h00000000, 32'hFFC00000, 32'h00000000};

  initial begin
    drive(1'b0, 32'h0, 5'b0, 1'b0);
    #2;
    check_state("reset");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check_state("post_reset");

    // ReLU / linear values, out_ready high, one push per cycle
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, relu_in[i], 5'b0, 1'b1);
      cycle("relu");
`ifdef NEURON_RELU_EN
      check_eq("relu_const", bus.out_data, relu_out[i]);
`else
      check_eq("linear_const", bus.out_data, relu_in[i]);
`endif
    end
    drive(1'b0, 32'h0, 5'b0, 1'b1);
    cycle("drain0");

    // Fill to full, fifth word must be refused
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h3F800000 + (32'(i) << 22) - ((i == 0) ? 32'h0 : 32'h0), 5'(i), 1'b0);
      if (i == 1) bus.in_data = 32'h40000000;
      if (i == 2) bus.in_data = 32'h40400000;
      if (i == 3) bus.in_data = 32'h40800000;
      if (i == 4) bus.in_data = 32'h40A00000;
      cycle("fill");
    end
    check_eq("full_count", 32'(count), 32'd4);
    check_eq("full_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b0, 32'h0, 5'b0, 1'b1);
    check_eq("head_first", bus.out_data, 32'h3F800000);
    cycle("pop_first");
    check_eq("ready_after_pop", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 3; i++) cycle("drain1");

    // Simultaneous push/pop at occupancy 2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom, 5'(i), 1'b0);
      cycle("pre2");
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h41000000 + 32'(i), 5'(i), 1'b1);
      cycle("pp");
      check_eq("pp_count2", 32'(count), 32'd2);
    end
    drive(1'b0, 32'h0, 5'b0, 1'b1);
    cycle("drain2");
    cycle("drain2");

    // Sticky accumulation and clear-with-push
    clear_sticky = 1'b1;
    cycle("clr");
    clear_sticky = 1'b0;
    drive(1'b1, 32'h3F800000, 5'b00001, 1'b1);
    cycle("stk1");
    drive(1'b1, 32'h3F800000, 5'b10000, 1'b1);
    cycle("stk2");
    check_eq("sticky_or", 32'(sticky_exceptions), 32'h11);
    drive(1'b1, 32'h3F800000, 5'b00100, 1'b1);
    clear_sticky = 1'b1;
    cycle("stk3");
    clear_sticky = 1'b0;
    check_eq("sticky_clr_push", 32'(sticky_exceptions), 32'h04);
    drive(1'b0, 32'h0, 5'b0, 1'b1);
    cycle("drain3");

    // Asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 5'b00010, 1'b0);
      cycle("pre_rst");
    end
    drive(1'b0, 32'h0, 5'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    q.delete();
    m_sticky = 5'b0;
    check_state("async_rst");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 32'h3FC00000, 5'b01000, 1'b0);
    cycle("after_rst");
    check_eq("after_rst_head", bus.out_data, 32'h3FC00000);
    drive(1'b0, 32'h0, 5'b0, 1'b1);
    cycle("drain4");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rand_word(), 5'($urandom), 1'($urandom_range(0, 2) != 0));
      clear_sticky = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/neuron_activation_fifo.md
# neuron_activation_fifo

- Buffered activation stage placed directly downstream of the floating-point dot-product / matrix-multiply block.
- Accepts each IEEE-754 result word and its 5-bit exception vector over a valid/ready handshake.
- Applies a ReLU activation, stores the word in a small FIFO and presents it to the next layer.
- Keeps a sticky OR of all accepted exception vectors for software/status readout.

## Interface
Parameters:
- exp_width, 8, exponent field width.
- mant_width, 24, mantissa width including hidden bit; data word is exp_width+mant_width bits, sign at MSB.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept a word this cycle.
- in_data  input  exp_width+mant_width  upstream FP result (c1).
- in_exceptions  input  5  upstream combined exception vector.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head this cycle.
- out_data  output  exp_width+mant_width  activated FP word at FIFO head.
- out_exceptions  output  5  exception vector stored with head entry.
- sticky_exceptions  output  5  OR of all accepted in_exceptions since reset/clear.
- clear_sticky  input  1  synchronous clear of sticky_exceptions.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Accept (push) when in_valid && in_ready; pop when out_valid && out_ready.
- in_ready = (count < DEPTH). It is registered-state only, with no combinational path from out_ready.
- ReLU at push:
  - If sign=1 and word is not NaN, store all-zeros (+0.0). This covers -0, negative finite, negative denormal and -inf.
  - NaN (exponent all ones, mantissa field nonzero) is stored unchanged, either sign.
  - Positive words are stored unchanged.
- in_exceptions is stored unmodified alongside the data; ReLU never alters exception bits.
- FIFO storage is circular, with read/write pointers of $clog2(DEPTH) bits that wrap naturally.
- out_data/out_exceptions are driven directly from the entry at the read pointer. They are don't-care while out_valid=0 but must hold stable while out_valid=1 && out_ready=0.
- out_valid = (count != 0).
- Simultaneous push and pop: count is unchanged, both pointers advance. This is legal at any occupancy 1..DEPTH-1.
  - When full, no push occurs.
  - When empty, no pop occurs, so no fall-through bypass.
- Sticky next = (clear_sticky ? 0 : sticky) | (push ? in_exceptions : 0). An exception accepted in the same cycle as clear is retained.

## Timing
- All outputs reset asynchronously on rst_n=0:
  - count=0, out_valid=0, in_ready=1 (after deassertion), sticky_exceptions=0.
  - Pointers =0; out_data/out_exceptions read entry 0.
  - Storage contents need not be reset.
- Latency: a word pushed at edge N is visible with out_valid=1 from edge N (registered), i.e. the cycle after acceptance. Minimum in-to-out latency is 1 cycle.
- Throughput: 1 word/cycle sustained when out_ready=1.
- in_ready falls the cycle after the DEPTH-th push and rises the cycle after the first pop from full.
- Reset asserted mid-operation discards all entries immediately; no partial pops.

## Configuration
- NEURON_RELU_EN defined: ReLU applied at push as described.
- NEURON_RELU_EN undefined: in_data stored and output bit-exact (linear activation); all handshake, FIFO and sticky behaviour is identical.

## Test plan
- ReLU values (NEURON_RELU_EN defined), out_ready=1, each pushed one cycle apart; check out_data one cycle after each push:
  - 0xC0400000 (-3.0) -> 0x00000000.
  - 0x40400000 (3.0) -> 0x40400000.
  - 0x80000000 -> 0x00000000.
  - 0xFFC00000 -> 0xFFC00000.
  - 0xFF800000 -> 0x00000000.
- Fill: out_ready=0, push 4 words 0x3F800000..0x40800000 -> count=4, in_ready=0 after 4th edge; a 5th in_valid is not accepted. Then out_ready=1 pops the words in order, and in_ready=1 the cycle after the first pop.
- Simultaneous push/pop at count=2 for 8 cycles -> count stays 2, output order equals input order across pointer wrap.
- Sticky: push exceptions 5'b00001 then 5'b10000 -> sticky=5'b10001. Then clear_sticky with a push of 5'b00100 in the same cycle -> sticky=5'b00100.
- Reset mid-stream: 3 entries queued, pulse rst_n low asynchronously -> count=0, out_valid=0, sticky=0 immediately; the next push emerges first.
- NEURON_RELU_EN undefined: push 0xC0400000 -> out_data=0xC0400000.
